// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR run controller and its shift-register core.
// Holds the controller state encoding and the default LFSR geometry.
package lfsr_pkg;

    // Controller states, two-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Default LFSR width.
    localparam int DEF_WIDTH = 6;

    // Default feedback taps: x^6 + x^5 + 1, maximal period 63.
    localparam logic [DEF_WIDTH-1:0] DEF_TAPS = 6'b110000;

    // Step count at which a run that never reaches its target gives up
    // (every non-zero state visited once: 2^WIDTH - 2 advances).
    localparam int DEF_MAX_STEPS = 62;

endpackage

// File: rtl/lfsr_core.sv
// WIDTH-bit Fibonacci LFSR with parallel load.
// The new bit enters at q[0]; it is the XOR of every q bit selected by TAPS.
// load wins over cen when both are high.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             cen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] tap_bits;
    logic [WIDTH-1:0] shift_val;

    // Mask each state bit with its tap so the feedback is one reduction XOR.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
            assign tap_bits[gi] = q_reg[gi] & TAPS[gi];
        end
    endgenerate

    // Shift towards the MSB; the feedback bit lands in bit 0.
    assign shift_val[0] = ^tap_bits;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shift_val[gi] = q_reg[gi-1];
        end
    endgenerate

    // Next-state select: load has priority, otherwise step when enabled.
    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = d;
        end else if (cen) begin
            q_next = shift_val;
        end
    end

    // State register, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Run controller for the LFSR counter.
// A start in IDLE latches seed and target, loads the LFSR for one cycle and
// then steps it until the state matches the target or the step budget runs
// out. The result (hit, steps) is held until the next accepted start.
// load, cen, busy and done are decoded from the registered state plus the
// live hold/abort inputs; err is registered so start/seed never reach an
// output combinationally.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS      = DEF_TAPS,
    parameter int               MAX_STEPS = DEF_MAX_STEPS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] count_to,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic             err,
    output logic [WIDTH-1:0] steps,
    output logic [WIDTH-1:0] q,
    output logic             load,
    output logic             cen
);

    localparam logic [WIDTH-1:0] STEP_LIMIT = WIDTH'(MAX_STEPS);
    localparam logic [WIDTH-1:0] STEP_ONE   = WIDTH'(1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] seed_next;
    logic [WIDTH-1:0] target_reg;
    logic [WIDTH-1:0] target_next;
    logic [WIDTH-1:0] steps_reg;
    logic [WIDTH-1:0] steps_next;
    logic             hit_reg;
    logic             hit_next;
    logic             err_reg;
    logic             err_next;

    logic             load_dec;
    logic             cen_dec;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] match_bits;
    logic             at_target;
    logic             at_limit;
    logic             seed_is_zero;

    // The shift register itself; the controller only drives load/cen.
    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (load_dec),
        .cen   (cen_dec),
        .d     (seed_reg),
        .q     (lfsr_q)
    );

    // Per-bit equality of the live LFSR state against the latched target.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_match
            assign match_bits[gi] = ~(lfsr_q[gi] ^ target_reg[gi]);
        end
    endgenerate

    assign at_target    = &match_bits;
    assign at_limit     = (steps_reg == STEP_LIMIT);
    assign seed_is_zero = (seed == '0);

    // Next-state, latch updates and strobe decode for the run sequencer.
    always_comb begin
        state_next  = state_reg;
        seed_next   = seed_reg;
        target_next = target_reg;
        steps_next  = steps_reg;
        hit_next    = hit_reg;
        err_next    = 1'b0;
        load_dec    = 1'b0;
        cen_dec     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (seed_is_zero) begin
                        // An all-zero seed would lock the LFSR; refuse it
                        // and leave the previous result visible.
                        err_next = 1'b1;
                    end else begin
                        seed_next   = seed;
                        target_next = count_to;
                        hit_next    = 1'b0;
                        steps_next  = '0;
                        state_next  = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    load_dec   = 1'b1;
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    hit_next   = 1'b0;
                    state_next = ST_IDLE;
                end else if (at_target) begin
                    hit_next   = 1'b1;
                    state_next = ST_DONE;
                end else if (at_limit) begin
                    hit_next   = 1'b0;
                    state_next = ST_DONE;
                end else if (!hold) begin
                    cen_dec    = 1'b1;
                    steps_next = steps_reg + STEP_ONE;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Controller registers, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            seed_reg   <= '0;
            target_reg <= '0;
            steps_reg  <= '0;
            hit_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            seed_reg   <= seed_next;
            target_reg <= target_next;
            steps_reg  <= steps_next;
            hit_reg    <= hit_next;
            err_reg    <= err_next;
        end
    end

    assign busy  = (state_reg != ST_IDLE);
    assign done  = (state_reg == ST_DONE);
    assign load  = load_dec;
    assign cen   = cen_dec;
    assign hit   = hit_reg;
    assign err   = err_reg;
    assign steps = steps_reg;
    assign q     = lfsr_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: directed scenarios plus randomized
// runs, each checked against a reference that walks the x^6+x^5+1 sequence.
module tb_lfsr_seq_ctrl;

    localparam int MAX_STEPS = 62;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       hold;
    logic [5:0] seed;
    logic [5:0] count_to;
    logic       busy;
    logic       done;
    logic       hit;
    logic       err;
    logic [5:0] steps;
    logic [5:0] q;
    logic       load;
    logic       cen;

    int         vectors;
    int         miscompares;
    int         done_cyc;
    int         cen_count;
    logic [5:0] q_seen[$];

    lfsr_seq_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .hold     (hold),
        .seed     (seed),
        .count_to (count_to),
        .busy     (busy),
        .done     (done),
        .hit      (hit),
        .err      (err),
        .steps    (steps),
        .q        (q),
        .load     (load),
        .cen      (cen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR step: shift left, new LSB = q[5] xor q[4].
    function automatic logic [5:0] lfsr_next(input logic [5:0] v);
        return {v[4:0], v[5] ^ v[4]};
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    // One complete run. hold_at/abort_at are step counts at which hold or
    // abort is raised (-1 for never). start stays high while busy to show it
    // is ignored, and seed/count_to are scrambled after acceptance.
    task automatic run_case(input string tag, input logic [5:0] s, input logic [5:0] t,
                            input int hold_at, input int hold_len, input int abort_at);
        logic [5:0] cur;
        logic [5:0] mq;
        int         k;
        bit         exp_hit;
        int         exp_holds;
        int         msteps;
        int         held;
        bit         fin;
        bit         do_hold;
        bit         do_abort;
        bit         exp_cen;

        // Expected outcome: first index of t in the sequence from s, or timeout.
        cur = s;
        k = MAX_STEPS;
        exp_hit = 1'b0;
        for (int i = 0; i <= MAX_STEPS; i++) begin
            if (cur == t) begin
                k = i;
                exp_hit = 1'b1;
                break;
            end
            cur = lfsr_next(cur);
        end
        exp_holds = (hold_at >= 0 && hold_at < k) ? hold_len : 0;

        q_seen.delete();
        cen_count = 0;
        done_cyc = -1;
        fin = 1'b0;

        start = 1'b1; seed = s; count_to = t;
        #1;
        chk(tag, "idle_busy", busy, 0);
        @(posedge clk); #1;
        seed = 6'($urandom); count_to = 6'($urandom);
        #1;
        chk(tag, "load", load, 1);
        chk(tag, "load_cen", cen, 0);
        chk(tag, "load_busy", busy, 1);
        chk(tag, "load_steps", steps, 0);
        chk(tag, "load_hit", hit, 0);
        @(posedge clk); #1;

        mq = s; msteps = 0; held = 0;
        for (int cyc = 2; cyc < 2 + MAX_STEPS + hold_len + 4; cyc++) begin
            do_abort = (abort_at >= 0 && msteps == abort_at);
            do_hold  = (hold_at >= 0 && msteps == hold_at && held < hold_len);
            abort = do_abort; hold = do_hold;
            #1;
            q_seen.push_back(q);
            if (cen) cen_count++;
            chk(tag, "run_q", q, mq);
            chk(tag, "run_steps", steps, msteps);
            chk(tag, "run_busy", busy, 1);
            chk(tag, "run_done", done, 0);
            chk(tag, "run_hit", hit, 0);
            exp_cen = !do_abort && (mq != t) && (msteps != MAX_STEPS) && !do_hold;
            chk(tag, "run_cen", cen, exp_cen);
            if (do_abort) begin
                @(posedge clk); #1;
                abort = 1'b0; hold = 1'b0; start = 1'b0;
                #1;
                chk(tag, "abort_busy", busy, 0);
                chk(tag, "abort_done", done, 0);
                chk(tag, "abort_hit", hit, 0);
                chk(tag, "abort_steps", steps, msteps);
                fin = 1'b1;
                break;
            end
            if (!exp_cen && !do_hold) begin
                @(posedge clk); #1;
                hold = 1'b0;
                #1;
                done_cyc = cyc + 1;
                chk(tag, "done", done, 1);
                chk(tag, "done_busy", busy, 1);
                chk(tag, "done_cen", cen, 0);
                chk(tag, "done_load", load, 0);
                chk(tag, "done_hit", hit, exp_hit);
                chk(tag, "done_steps", steps, k);
                chk(tag, "done_cycle", done_cyc, 3 + k + exp_holds);
                @(posedge clk); #1;
                start = 1'b0;
                #1;
                chk(tag, "post_done", done, 0);
                chk(tag, "post_busy", busy, 0);
                chk(tag, "post_hit", hit, exp_hit);
                chk(tag, "post_steps", steps, k);
                fin = 1'b1;
                break;
            end
            if (exp_cen) begin
                mq = lfsr_next(mq);
                msteps++;
            end
            if (do_hold) held++;
            @(posedge clk); #1;
        end
        hold = 1'b0; abort = 1'b0; start = 1'b0;
        vectors++;
        assert (fin)
        else begin
            miscompares++;
            $error("FAIL %s/timeout: observed no completion expected done within budget", tag);
        end
        $display("run %s seed=%02h target=%02h -> hit=%0d steps=%0d done_cycle=%0d cen_cycles=%0d",
                 tag, s, t, hit, steps, done_cyc, cen_count);
    endtask

    // Bound the whole run in case the DUT never finishes a phase.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] exp2 [5];
        logic [5:0] rs;
        logic [5:0] rt;
        int         zero_cnt;
        int         frozen;
        int         h_at;
        int         h_len;
        int         a_at;

        vectors = 0;
        miscompares = 0;
        exp2[0] = 6'h0B; exp2[1] = 6'h16; exp2[2] = 6'h2D; exp2[3] = 6'h1B; exp2[4] = 6'h37;

        reset = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
        seed = 6'h00; count_to = 6'h00;

        // Reset state.
        #12;
        chk("reset", "q", q, 0);
        chk("reset", "steps", steps, 0);
        chk("reset", "hit", hit, 0);
        chk("reset", "done", done, 0);
        chk("reset", "err", err, 0);
        chk("reset", "busy", busy, 0);
        chk("reset", "load", load, 0);
        chk("reset", "cen", cen, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic hit: 4 steps, done in cycle N+7, exact q trace.
        run_case("s2_hit", 6'h0B, 6'h37, -1, 0, -1);
        chk("s2_hit", "trace_len", q_seen.size(), 5);
        for (int i = 0; i < 5 && i < q_seen.size(); i++) begin
            chk("s2_hit", $sformatf("trace%0d", i), q_seen[i], exp2[i]);
        end
        chk("s2_hit", "cen_cycles", cen_count, 4);
        chk("s2_hit", "done_n7", done_cyc, 7);

        // Zero seed rejected: err pulse, previous result kept.
        start = 1'b1; seed = 6'h00; count_to = 6'h2A;
        #1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("s4_err", "err", err, 1);
        chk("s4_err", "busy", busy, 0);
        chk("s4_err", "load", load, 0);
        chk("s4_err", "hit", hit, 1);
        chk("s4_err", "steps", steps, 4);
        @(posedge clk); #1;
        chk("s4_err", "err_pulse", err, 0);
        chk("s4_err", "busy_after", busy, 0);
        $display("run s4_err seed=00 -> err pulse, hit=%0d steps=%0d", hit, steps);

        // Target zero never hits: full timeout.
        run_case("s3_timeout", 6'h0B, 6'h00, -1, 0, -1);
        chk("s3_timeout", "cen_cycles", cen_count, 62);
        zero_cnt = 0;
        foreach (q_seen[i]) if (q_seen[i] == 6'h00) zero_cnt++;
        chk("s3_timeout", "q_never_zero", zero_cnt, 0);

        // Hold for 3 cycles after the second step.
        run_case("s5_hold", 6'h0B, 6'h37, 2, 3, -1);
        frozen = 0;
        for (int i = 2; i < 6 && i < q_seen.size(); i++) if (q_seen[i] == 6'h2D) frozen++;
        chk("s5_hold", "q_frozen", frozen, 4);
        chk("s5_hold", "cen_cycles", cen_count, 4);
        chk("s5_hold", "done_n10", done_cyc, 10);

        // Abort after 2 steps with start held high while busy.
        run_case("s6_abort", 6'h0B, 6'h37, -1, 0, 2);
        @(posedge clk); #1;
        chk("s6_abort", "still_idle", busy, 0);
        chk("s6_abort", "no_done", done, 0);
        // Seed equal to target: immediate hit.
        run_case("s6_same", 6'h15, 6'h15, -1, 0, -1);
        chk("s6_same", "done_n3", done_cyc, 3);

        // Abort during LOAD.
        start = 1'b1; seed = 6'h0B; count_to = 6'h37;
        #1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b1;
        #1;
        chk("load_abort", "busy", busy, 1);
        chk("load_abort", "cen", cen, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        #1;
        chk("load_abort", "busy_after", busy, 0);
        chk("load_abort", "done_after", done, 0);
        @(posedge clk); #1;
        chk("load_abort", "done_later", done, 0);
        $display("run load_abort seed=0b -> busy=%0d done=%0d", busy, done);

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            rs = 6'($urandom_range(1, 63));
            if (r % 3 == 0) begin
                rt = 6'($urandom_range(0, 63));
            end else begin
                rt = rs;
                for (int j = $urandom_range(0, 62); j > 0; j--) rt = lfsr_next(rt);
            end
            h_at  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : -1;
            h_len = int'($urandom_range(1, 4));
            a_at  = (r == 4 || r == 8) ? int'($urandom_range(0, 3)) : -1;
            run_case($sformatf("rand%0d", r), rs, rt, h_at, h_len, a_at);
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a run.
        start = 1'b1; seed = 6'h0B; count_to = 6'h00;
        #1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        chk("mid_reset", "busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_reset", "q", q, 0);
        chk("mid_reset", "steps", steps, 0);
        chk("mid_reset", "hit", hit, 0);
        chk("mid_reset", "done", done, 0);
        chk("mid_reset", "err", err, 0);
        chk("mid_reset", "busy", busy, 0);
        chk("mid_reset", "load", load, 0);
        chk("mid_reset", "cen", cen, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        $display("run mid_reset -> outputs cleared, busy=%0d q=%02h", busy, q);
        @(posedge clk); #1;
        run_case("post_reset", 6'h0B, 6'h37, -1, 0, -1);
        chk("post_reset", "done_n7", done_cyc, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
Run controller for the team's 6-bit LFSR counter. It takes a seed and a target value (count_to), loads the LFSR, and clocks it with cen until the state equals the target or the sequence is exhausted. It reports hit/step count through a start/busy/done handshake. It replaces the hand-driven load/cen stimulus with a reusable sequencer that upper logic or a CPU-side register block can drive.

Parameters:
WIDTH, 6, LFSR/seed/count_to width
TAPS, 6'b110000, feedback tap mask (bit i set means q[i] is XORed into the feedback); default gives x^6+x^5+1, maximal period 63
MAX_STEPS, 62, step count at which a non-hit run times out (2^WIDTH-2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request a run; sampled only in IDLE
abort  in  1  cancel a run in LOAD/RUN
hold  in  1  pause stepping while in RUN
seed  in  WIDTH  LFSR start value; sampled with start
count_to  in  WIDTH  target value; sampled with start
busy  out  1  high in LOAD, RUN, DONE
done  out  1  one-cycle pulse when a run completes
hit  out  1  last run reached count_to; held until next accepted start
err  out  1  one-cycle pulse: start with seed==0 rejected
steps  out  WIDTH  LFSR advances taken in last/current run
q  out  WIDTH  current LFSR state
load  out  1  LFSR parallel-load strobe (observable)
cen  out  1  LFSR count enable (observable)

Behaviour:
- Reset (reset=0, async): state=IDLE; q=0, steps=0, hit=0, done=0, err=0, busy=0, load=0, cen=0; latched seed and target = 0.
- LFSR step when cen=1: q <= {q[WIDTH-2:0], ^(q & TAPS)}. When load=1: q <= latched seed. load has priority over cen; they are never both high.
- IDLE: start=1 and seed!=0 -> latch seed and count_to, clear hit and steps, go to LOAD. start=1 and seed==0 -> err=1 for one cycle, stay in IDLE, no change to hit or steps.
- LOAD (1 cycle): load=1 and cen=0. q=seed after this edge. Next state is RUN.
- RUN, evaluated each cycle in priority order:
  1. abort=1 -> IDLE, cen=0, hit=0, no done pulse.
  2. q==target -> DONE with hit=1, cen=0, no step.
  3. steps==MAX_STEPS -> DONE with hit=0, cen=0.
  4. hold=1 -> cen=0, stay in RUN.
  5. Otherwise cen=1, q steps, steps+1.
- DONE (1 cycle): done=1, busy=1. Next state is IDLE. hit and steps hold their values.
- abort in LOAD -> IDLE, no done pulse. abort in IDLE or DONE is ignored.
- start while busy is ignored, not queued. seed and count_to changes during a run have no effect.
- Latency: start accepted at edge N -> load high in cycle N+1 -> first RUN compare in cycle N+2. With k steps to a hit, done pulses in cycle N+3+k.
- Target equal to seed: hit with steps=0. count_to==0 never hits -> timeout with steps=MAX_STEPS, hit=0.
- cen, load, busy, done, err are decoded from registered state plus current inputs (hold/abort); no other comb paths from inputs.

Decomposition:
- Shared package/header lfsr_pkg: state encodings (IDLE, LOAD, RUN, DONE, 2 bits), default WIDTH/TAPS/MAX_STEPS.
- One sub-module: lfsr_core (clk, reset, load, cen, d, q). It is the WIDTH-bit shift register with parallel load and TAPS feedback. The controller instantiates it and owns the FSM, latches, step counter and comparator.

Test Plan:
1. Reset mid-RUN (reset low at an arbitrary edge) -> all outputs 0 immediately (async), state IDLE. After release, start works normally.
2. seed=6'b001011, count_to=6'b110111, start pulse -> q sequence 0x0B, 0x16, 0x2D, 0x1B, 0x37; cen high 4 cycles; done pulse with hit=1, steps=4; done in cycle N+7.
3. seed=6'b001011, count_to=0 -> 62 cen cycles, done with hit=0, steps=62; q never 0.
4. seed=0, start -> err pulse 1 cycle, busy stays 0, hit and steps unchanged from previous run.
5. Run from scenario 2 with hold=1 for 3 cycles after the 2nd step -> cen low 3 cycles, q frozen at 0x2D; final result still hit=1, steps=4, done 3 cycles later.
6. abort during RUN after 2 steps, plus start asserted while busy -> no done pulse, hit=0, state IDLE next cycle; the busy-time start is ignored. A new start with seed=count_to=0x15 -> hit=1, steps=0.
